// File: rtl/pb_keypad.sv
// 4x4 keypad scanner with 2-flop column sync, frame debounce and a 4-entry key-code FIFO on the Picoblaze port bus.
// Latency: DEBOUNCE frames of 4*SCAN_DIV+1 cycles from a stable press to the FIFO; reads return registered data one cycle later.
// Backpressure: none; a push into a full FIFO is dropped and flagged as sticky overflow.
module pb_keypad #(
    parameter logic [7:0]  BASE_ADDRESS = 8'h20,
    parameter logic [15:0] SCAN_DIV     = 16'd50000,
    parameter int          DEBOUNCE     = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] port_id,
    input  logic [7:0] data_in,
    input  logic       read_strobe,
    input  logic       write_strobe,
    output logic [7:0] data_out,
    output logic       interrupt,
    output logic [3:0] row,
    input  logic [3:0] col
);

    localparam logic [15:0] DIV_LAST = SCAN_DIV - 16'd1;
    localparam logic [2:0]  DB       = 3'(DEBOUNCE);

    typedef enum logic {DRIVE, EVAL} state_t;

    state_t      state_q, state_d;
    logic [3:0]  col_s1, col_s2;
    logic [1:0]  r_q, r_d;
    logic [15:0] div_q, div_d;
    logic [15:0] frame_q, frame_d, prev_q, prev_d, stable_q, stable_d, new_keys;
    logic [2:0]  cnt_q, cnt_d;
    logic        push;
    logic [3:0]  push_code;

    logic [3:0]  mem [0:3];
    logic [1:0]  wr_ptr, rd_ptr;
    logic [2:0]  count;
    logic        overflow, irq_en;
    logic        not_empty, full, pop_req, ctrl_wr, flush, clr_ovf;
    logic        do_push, do_pop, ovf_set;
    logic [7:0]  rd_mux;
    logic        unused_data;

    assign unused_data = ^data_in[7:3];
    assign row = ~(4'b0001 << r_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_s1   <= 4'hF;
            col_s2   <= 4'hF;
            state_q  <= DRIVE;
            r_q      <= 2'd0;
            div_q    <= 16'd0;
            frame_q  <= 16'd0;
            prev_q   <= 16'd0;
            stable_q <= 16'd0;
            cnt_q    <= 3'd0;
        end else begin
            col_s1   <= col;
            col_s2   <= col_s1;
            state_q  <= state_d;
            r_q      <= r_d;
            div_q    <= div_d;
            frame_q  <= frame_d;
            prev_q   <= prev_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        r_d       = r_q;
        div_d     = div_q;
        frame_d   = frame_q;
        prev_d    = prev_q;
        stable_d  = stable_q;
        cnt_d     = cnt_q;
        new_keys  = 16'd0;
        push      = 1'b0;
        push_code = 4'd0;
        case (state_q)
            DRIVE: begin
                if (div_q == DIV_LAST) begin
                    div_d = 16'd0;
                    frame_d[{r_q, 2'b00} +: 4] = ~col_s2;
                    if (r_q == 2'd3) begin
                        r_d     = 2'd0;
                        state_d = EVAL;
                    end else begin
                        r_d = r_q + 2'd1;
                    end
                end else begin
                    div_d = div_q + 16'd1;
                end
            end
            EVAL: begin
                state_d = DRIVE;
                prev_d  = frame_q;
                if (frame_q == prev_q)
                    cnt_d = (cnt_q == 3'd7) ? 3'd7 : cnt_q + 3'd1;
                else
                    cnt_d = 3'd1;
                // Only a debounced frame can report presses; new bits are judged against the old stable map.
                if (cnt_d >= DB) begin
                    stable_d = frame_q;
                    new_keys = frame_q & ~stable_q;
                    push     = |new_keys;
                    for (int i = 15; i >= 0; i--)
                        if (new_keys[i]) push_code = 4'(i);
                end
            end
            default: state_d = DRIVE;
        endcase
    end

    assign not_empty = (count != 3'd0);
    assign full      = (count == 3'd4);
    assign pop_req   = read_strobe && (port_id == BASE_ADDRESS + 8'd1);
    assign ctrl_wr   = write_strobe && (port_id == BASE_ADDRESS + 8'd2);
    assign flush     = ctrl_wr & data_in[2];
    assign clr_ovf   = ctrl_wr & data_in[1];
    assign do_pop    = pop_req & not_empty & ~flush;
    assign do_push   = push & ~flush & (~full | do_pop);
    assign ovf_set   = push & ~flush & full & ~do_pop;

    always_comb begin
        rd_mux = 8'h00;
        if (port_id == BASE_ADDRESS)
            rd_mux = {4'b0000, irq_en, overflow, full, not_empty};
        else if (port_id == BASE_ADDRESS + 8'd1)
            rd_mux = not_empty ? {4'h0, mem[rd_ptr]} : 8'h00;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) mem[i] <= 4'd0;
            wr_ptr    <= 2'd0;
            rd_ptr    <= 2'd0;
            count     <= 3'd0;
            overflow  <= 1'b0;
            irq_en    <= 1'b0;
            interrupt <= 1'b0;
            data_out  <= 8'h00;
        end else begin
            if (flush) begin
                wr_ptr <= 2'd0;
                rd_ptr <= 2'd0;
                count  <= 3'd0;
            end else begin
                if (do_push) begin
                    mem[wr_ptr] <= push_code;
                    wr_ptr      <= wr_ptr + 2'd1;
                end
                if (do_pop)
                    rd_ptr <= rd_ptr + 2'd1;
                if (do_push && !do_pop)
                    count <= count + 3'd1;
                else if (do_pop && !do_push)
                    count <= count - 3'd1;
            end
            overflow  <= (overflow & ~clr_ovf) | ovf_set;
            if (ctrl_wr)
                irq_en <= data_in[0];
            interrupt <= irq_en & not_empty;
            data_out  <= rd_mux;
        end
    end

endmodule

// File: tb/tb_pb_keypad.sv
// Bench for pb_keypad: keypad matrix model drives col from row; expected key codes are queued on press and popped on DATA reads.
module tb_pb_keypad;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] port_id, data_in;
    logic       read_strobe, write_strobe;
    logic [7:0] data_out;
    logic       interrupt;
    logic [3:0] row, col;
    logic [15:0] keys;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];
    logic       exp_ovf;
    logic       exp_irq_en;

    always #5 clk = ~clk;

    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!row[r] && keys[r*4+c]) col[c] = 1'b0;
    end

    pb_keypad #(.BASE_ADDRESS(8'h20), .SCAN_DIV(16'd4), .DEBOUNCE(3)) dut (
        .clk(clk), .reset(reset), .port_id(port_id), .data_in(data_in),
        .read_strobe(read_strobe), .write_strobe(write_strobe),
        .data_out(data_out), .interrupt(interrupt), .row(row), .col(col)
    );

    function automatic logic [7:0] exp_status();
        return {4'b0000, exp_irq_en, exp_ovf, exp_q.size() == 4, exp_q.size() != 0};
    endfunction

    task automatic sb_push(input logic [7:0] code);
        if (exp_q.size() < 4) exp_q.push_back(code);
        else exp_ovf = 1'b1;
    endtask

    // Returns at the negedge inside the one-cycle EVAL state (row scan just wrapped from row 3).
    task automatic wait_eval();
        logic [3:0] prev;
        bit found;
        prev  = row;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (prev == 4'b0111 && row == 4'b1110) found = 1;
            prev = row;
        end
        if (!found) begin
            n_cmp++; n_err++;
            $display("FAIL wait_eval: no EVAL within 100 cycles, row=%b", row);
        end
    endtask

    task automatic read_reg(input logic [7:0] addr, output logic [7:0] val);
        port_id = addr; read_strobe = 1'b1;
        @(negedge clk);
        read_strobe = 1'b0; port_id = 8'h00;
        val = data_out;
    endtask

    task automatic write_reg(input logic [7:0] addr, input logic [7:0] d);
        port_id = addr; data_in = d; write_strobe = 1'b1;
        @(negedge clk);
        write_strobe = 1'b0; port_id = 8'h00; data_in = 8'h00;
    endtask

    // Press key k at a frame boundary; returns in the EVAL cycle whose closing edge pushes it.
    task automatic press_start(input int k);
        wait_eval();
        keys = 16'd0;
        keys[k] = 1'b1;
        repeat (3) wait_eval();
    endtask

    task automatic release_keys();
        keys = 16'd0;
        repeat (4) wait_eval();
    endtask

    task automatic test_reset();
        logic [7:0] v;
        repeat (3) @(negedge clk);
        n_cmp++; if (row !== 4'b1110) begin n_err++; $display("FAIL reset_row: got %b want 1110", row); end
        n_cmp++; if (data_out !== 8'h00) begin n_err++; $display("FAIL reset_data_out: got %h want 00", data_out); end
        n_cmp++; if (interrupt !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b want 0", interrupt); end
        reset = 1'b1;
        @(negedge clk);
        read_reg(8'h20, v);
        n_cmp++; if (v !== 8'h00) begin n_err++; $display("FAIL reset_status: got %h want 00", v); end
    endtask

    task automatic test_single_key();
        logic [7:0] v, e;
        press_start(9);
        sb_push(8'h09);
        wait_eval();
        release_keys();
        read_reg(8'h20, v);
        n_cmp++; if (v !== 8'h01) begin n_err++; $display("FAIL single_status: got %h want 01", v); end
        read_reg(8'h21, v);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        n_cmp++; if (v !== e) begin n_err++; $display("FAIL single_data: got %h want %h", v, e); end
        read_reg(8'h20, v);
        n_cmp++; if (v !== 8'h00) begin n_err++; $display("FAIL single_status_after: got %h want 00", v); end
        read_reg(8'h21, v);
        n_cmp++; if (v !== 8'h00) begin n_err++; $display("FAIL empty_data: got %h want 00", v); end
    endtask

    task automatic test_bounce();
        logic [7:0] v;
        wait_eval();
        for (int i = 0; i < 7; i++) begin
            keys = (i % 2 == 0) ? 16'h0200 : 16'h0000;
            wait_eval();
        end
        keys = 16'h0200;
        wait_eval();
        release_keys();
        read_reg(8'h20, v);
        n_cmp++; if (v !== exp_status()) begin n_err++; $display("FAIL bounce_status: got %h want %h", v, exp_status()); end
    endtask

    task automatic test_overflow();
        logic [7:0] v, e;
        int ks[5] = '{0, 5, 10, 15, 3};
        foreach (ks[i]) begin
            press_start(ks[i]);
            sb_push(8'(ks[i]));
            release_keys();
        end
        read_reg(8'h20, v);
        n_cmp++; if (v !== exp_status()) begin n_err++; $display("FAIL ovf_status: got %h want %h", v, exp_status()); end
        write_reg(8'h22, 8'h02);
        exp_ovf = 1'b0;
        read_reg(8'h20, v);
        n_cmp++; if (v !== exp_status()) begin n_err++; $display("FAIL ovf_clear_status: got %h want %h", v, exp_status()); end
        for (int i = 0; i < 4; i++) begin
            read_reg(8'h21, v);
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
            n_cmp++; if (v !== e) begin n_err++; $display("FAIL ovf_data%0d: got %h want %h", i, v, e); end
        end
        read_reg(8'h20, v);
        n_cmp++; if (v !== 8'h00) begin n_err++; $display("FAIL ovf_drained: got %h want 00", v); end
    endtask

    task automatic test_irq();
        logic [7:0] v, e;
        write_reg(8'h22, 8'h01);
        exp_irq_en = 1'b1;
        read_reg(8'h20, v);
        n_cmp++; if (v !== 8'h08) begin n_err++; $display("FAIL irq_status: got %h want 08", v); end
        press_start(0);
        sb_push(8'h00);
        n_cmp++; if (interrupt !== 1'b0) begin n_err++; $display("FAIL irq_before_push: got %b want 0", interrupt); end
        @(negedge clk);
        n_cmp++; if (interrupt !== 1'b0) begin n_err++; $display("FAIL irq_push_cycle: got %b want 0", interrupt); end
        @(negedge clk);
        n_cmp++; if (interrupt !== 1'b1) begin n_err++; $display("FAIL irq_rise: got %b want 1", interrupt); end
        release_keys();
        read_reg(8'h21, v);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        n_cmp++; if (v !== e) begin n_err++; $display("FAIL irq_data: got %h want %h", v, e); end
        n_cmp++; if (interrupt !== 1'b1) begin n_err++; $display("FAIL irq_pop_cycle: got %b want 1", interrupt); end
        @(negedge clk);
        n_cmp++; if (interrupt !== 1'b0) begin n_err++; $display("FAIL irq_fall: got %b want 0", interrupt); end
        write_reg(8'h22, 8'h00);
        exp_irq_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] v, e;
        int ks[4] = '{1, 6, 11, 12};
        foreach (ks[i]) begin
            press_start(ks[i]);
            sb_push(8'(ks[i]));
            release_keys();
        end
        press_start(14);
        port_id = 8'h21; read_strobe = 1'b1;
        @(negedge clk);
        read_strobe = 1'b0; port_id = 8'h00;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        n_cmp++; if (data_out !== e) begin n_err++; $display("FAIL b2b_pop: got %h want %h", data_out, e); end
        sb_push(8'd14);
        release_keys();
        read_reg(8'h20, v);
        n_cmp++; if (v !== exp_status()) begin n_err++; $display("FAIL b2b_status: got %h want %h", v, exp_status()); end
        for (int i = 0; i < 4; i++) begin
            read_reg(8'h21, v);
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
            n_cmp++; if (v !== e) begin n_err++; $display("FAIL b2b_data%0d: got %h want %h", i, v, e); end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] v;
        logic [7:0] offs[5] = '{8'h23, 8'h1F, 8'h00, 8'hFF, 8'h24};
        bit found;
        write_reg(8'h22, 8'h01);
        exp_irq_en = 1'b1;
        press_start(2);  sb_push(8'd2);  release_keys();
        press_start(7);  sb_push(8'd7);  release_keys();
        port_id = 8'h20;
        @(negedge clk);
        n_cmp++; if (data_out !== exp_status()) begin n_err++; $display("FAIL pre_reset_status: got %h want %h", data_out, exp_status()); end
        n_cmp++; if (interrupt !== 1'b1) begin n_err++; $display("FAIL pre_reset_irq: got %b want 1", interrupt); end
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (row == 4'b1011) found = 1;
        end
        n_cmp++; if (!found) begin n_err++; $display("FAIL mid_drive_wait: row=%b want 1011 within 100 cycles", row); end
        #2 reset = 1'b0;
        #1;
        n_cmp++; if (row !== 4'b1110) begin n_err++; $display("FAIL mid_reset_row: got %b want 1110", row); end
        n_cmp++; if (data_out !== 8'h00) begin n_err++; $display("FAIL mid_reset_data_out: got %h want 00", data_out); end
        n_cmp++; if (interrupt !== 1'b0) begin n_err++; $display("FAIL mid_reset_irq: got %b want 0", interrupt); end
        exp_q.delete();
        exp_ovf = 1'b0;
        exp_irq_en = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        port_id = 8'h00;
        @(negedge clk);
        read_reg(8'h20, v);
        n_cmp++; if (v !== exp_status()) begin n_err++; $display("FAIL post_reset_status: got %h want %h", v, exp_status()); end
        read_reg(8'h21, v);
        n_cmp++; if (v !== 8'h00) begin n_err++; $display("FAIL post_reset_data: got %h want 00", v); end
        foreach (offs[i]) begin
            read_reg(offs[i], v);
            n_cmp++; if (v !== 8'h00) begin n_err++; $display("FAIL off_range_%h: got %h want 00", offs[i], v); end
        end
    endtask

    initial begin
        reset = 1'b0;
        port_id = 8'h00; data_in = 8'h00;
        read_strobe = 1'b0; write_strobe = 1'b0;
        keys = 16'd0;
        exp_ovf = 1'b0;
        exp_irq_en = 1'b0;
        test_reset();
        test_single_key();
        test_bounce();
        test_overflow();
        test_irq();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
